// File: rtl/imem_loader_pkg.sv
// Shared IM geometry and loader FSM state encoding.
package imem_loader_pkg;

  localparam int IM_ADDR_WIDTH = 10;
  localparam int IM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_release_timer.sv
// Purpose: loadable down-counter that flags the last cycle of the core-release hold.
// Latency: expire is high during the DELAY-th cycle after the load edge.
// Backpressure: none; free-running once loaded.
module release_timer #(
  parameter int DELAY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int CW = $clog2(DELAY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(DELAY);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Counting down from DELAY, a value of 1 means the next edge is the DELAY-th.
  assign expire = (cnt == CW'(1));

endmodule

// File: rtl/imem_loader.sv
// Purpose: boot-time IM writer; streams words to addresses 0.. and holds the core in reset until done.
// Latency: IM write one cycle after each handshake; PC_Rst drops RELEASE_DELAY edges after the last one.
// Backpressure: In_Ready is high only in LOAD and drops on the edge that accepts the final word.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH    = IM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = IM_DATA_WIDTH,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   WordCount,
  input  logic                  In_Valid,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  In_Ready,
  output logic                  IM_WrEn,
  output logic [ADDR_WIDTH-1:0] IM_WrAddr,
  output logic [DATA_WIDTH-1:0] IM_WrData,
  output logic                  PC_Rst,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Error
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [ADDR_WIDTH:0]   remaining, remaining_nxt;
  logic                  in_ready_nxt, wren_nxt, pc_rst_nxt, busy_nxt, done_nxt, error_nxt;
  logic [ADDR_WIDTH-1:0] wraddr_nxt;
  logic [DATA_WIDTH-1:0] wrdata_nxt;
  logic                  timer_load, timer_expire;

  release_timer #(
    .DELAY (RELEASE_DELAY)
  ) u_release_timer (
    .clk    (Clk),
    .rst    (Rst),
    .load   (timer_load),
    .expire (timer_expire)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      In_Ready  <= 1'b0;
      IM_WrEn   <= 1'b0;
      IM_WrAddr <= '0;
      IM_WrData <= '0;
      PC_Rst    <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      In_Ready  <= in_ready_nxt;
      IM_WrEn   <= wren_nxt;
      IM_WrAddr <= wraddr_nxt;
      IM_WrData <= wrdata_nxt;
      PC_Rst    <= pc_rst_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      Error     <= error_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    in_ready_nxt  = In_Ready;
    wren_nxt      = 1'b0;
    wraddr_nxt    = IM_WrAddr;
    wrdata_nxt    = IM_WrData;
    pc_rst_nxt    = PC_Rst;
    busy_nxt      = Busy;
    done_nxt      = Done;
    error_nxt     = Error;
    timer_load    = 1'b0;

    case (state)
      ST_IDLE, ST_RUN: begin
        // A rejected Start only flags Error; a running core keeps running.
        if (Start) begin
          if (WordCount > MAX_WORDS) begin
            error_nxt = 1'b1;
          end else begin
            error_nxt  = 1'b0;
            pc_rst_nxt = 1'b1;
            done_nxt   = 1'b0;
            busy_nxt   = 1'b1;
            addr_nxt   = '0;
            if (WordCount == '0) begin
              state_nxt  = ST_RELEASE;
              timer_load = 1'b1;
            end else begin
              state_nxt     = ST_LOAD;
              remaining_nxt = WordCount;
              in_ready_nxt  = 1'b1;
            end
          end
        end
      end

      ST_LOAD: begin
        if (In_Valid && In_Ready) begin
          wren_nxt      = 1'b1;
          wraddr_nxt    = addr;
          wrdata_nxt    = In_Data;
          addr_nxt      = addr + 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == (ADDR_WIDTH+1)'(1)) begin
            state_nxt    = ST_RELEASE;
            in_ready_nxt = 1'b0;
            timer_load   = 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (timer_expire) begin
          state_nxt  = ST_RUN;
          pc_rst_nxt = 1'b0;
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: per-cycle output vectors compared against a transaction-level model.
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int RD   = 4;
  localparam int MAXL = 1040;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Start = 1'b0;
  logic [AW:0]   WordCount = '0;
  logic          In_Valid = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Ready, IM_WrEn, PC_Rst, Busy, Done, Error;
  logic [AW-1:0] IM_WrAddr;
  logic [DW-1:0] IM_WrData;

  imem_loader #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .RELEASE_DELAY (RD)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Start     (Start),
    .WordCount (WordCount),
    .In_Valid  (In_Valid),
    .In_Data   (In_Data),
    .In_Ready  (In_Ready),
    .IM_WrEn   (IM_WrEn),
    .IM_WrAddr (IM_WrAddr),
    .IM_WrData (IM_WrData),
    .PC_Rst    (PC_Rst),
    .Busy      (Busy),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus, observed and expected output vectors.
  // Vector layout: {wren, addr[9:0], data[31:0], rdy, pc_rst, done, busy, err}.
  logic          pat_s  [MAXL];
  logic [AW:0]   pat_wc [MAXL];
  logic          pat_v  [MAXL];
  logic [DW-1:0] pat_d  [MAXL];
  logic [47:0]   obs_vec[MAXL];
  logic [47:0]   exp_vec[MAXL];

  logic cur_running = 1'b0;
  logic cur_err     = 1'b0;

  localparam logic [47:0] RST_VEC = {1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic logic [47:0] obs_now();
    return {IM_WrEn, IM_WrAddr, IM_WrData, In_Ready, PC_Rst, Done, Busy, Error};
  endfunction

  // Write address/data are only meaningful on cycles where a write is expected.
  function automatic logic [47:0] mask_of(input logic [47:0] e);
    logic [47:0] m;
    m = '1;
    if (!e[47]) m[46:5] = '0;
    return m;
  endfunction

  task automatic set_pattern(input int wc, input int len, input int pct);
    for (int i = 0; i < len; i++) begin
      pat_s[i]  = 1'b0;
      pat_wc[i] = (AW+1)'($urandom_range(0, 2047));
      pat_v[i]  = (int'($urandom_range(0, 99)) < pct);
      pat_d[i]  = $urandom;
    end
    pat_s[0]       = 1'b1;
    pat_wc[0]      = (AW+1)'(wc);
    pat_v[0]       = 1'b0;
    pat_v[len-1]   = 1'b0;
  endtask

  // Index i: sample outputs at negedge i, then drive the inputs seen by the following posedge.
  task automatic run_cycles(input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      obs_vec[i] = obs_now();
      Start      = pat_s[i];
      WordCount  = pat_wc[i];
      In_Valid   = pat_v[i];
      In_Data    = pat_d[i];
    end
  endtask

  // Model: the first n valid cycles after Start are accepted; word k lands at address k one
  // cycle later; the core is released RD edges after the last acceptance.
  task automatic model_run(input int n, input int len);
    logic          is_bad, hs, loading, released, r0, e0;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    int            k, c_last;
    is_bad = (n > (1 << AW));
    r0     = cur_running;
    e0     = cur_err;
    k      = 0;
    c_last = (!is_bad && n == 0) ? 0 : -1;
    hs     = 1'b0;
    wa     = '0;
    wd     = '0;
    exp_vec[0] = {1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b0, !r0, r0, 1'b0, e0};
    for (int i = 1; i < len; i++) begin
      loading  = !is_bad && (k < n);
      released = (c_last >= 0) && (i >= c_last + RD + 1);
      if (is_bad) exp_vec[i] = {hs, wa, wd, 1'b0, !r0, r0, 1'b0, 1'b1};
      else        exp_vec[i] = {hs, wa, wd, loading, !released, released, !released, 1'b0};
      hs = loading && pat_v[i];
      if (hs) begin
        wa = AW'(k);
        wd = pat_d[i];
        k++;
        if (k == n) c_last = i;
      end
    end
    if (is_bad) begin
      cur_err = 1'b1;
    end else begin
      cur_err     = 1'b0;
      cur_running = (c_last >= 0) && (len - 1 >= c_last + RD + 1);
    end
  endtask

  task automatic test_reset();
    #2 Rst = 1'b1;
    #1;
    total++;
    if (obs_now() !== RST_VEC) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs_now(), RST_VEC);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      total++;
      if (obs_now() !== RST_VEC) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", c, obs_now(), RST_VEC);
      end
    end
    Rst = 1'b0;
    cur_running = 1'b0;
    cur_err     = 1'b0;
  endtask

  task automatic test_bad_count();
    logic [47:0] m;
    // Oversized count from IDLE, then a legal one-word load, then oversized from RUN.
    int wcs[3] = '{1025, 1, 2047};
    for (int t = 0; t < 3; t++) begin
      set_pattern(wcs[t], 16, 100);
      model_run(wcs[t], 16);
      run_cycles(16);
      for (int i = 0; i < 16; i++) begin
        m = mask_of(exp_vec[i]);
        total++;
        if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
          bad++;
          $display("FAIL bad_count wc=%0d cyc=%0d got=%h want=%h", wcs[t], i, obs_vec[i] & m, exp_vec[i] & m);
        end
      end
    end
  endtask

  task automatic test_basic_load();
    logic [47:0] m;
    set_pattern(3, 14, 100);
    pat_d[1] = 32'h20080001;
    pat_d[2] = 32'h20090002;
    pat_d[3] = 32'h01095020;
    model_run(3, 14);
    run_cycles(14);
    for (int i = 0; i < 14; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL basic_load cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
  endtask

  task automatic test_gapped_load();
    logic [47:0] m;
    logic        vp[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    set_pattern(4, 18, 0);
    for (int i = 0; i < 7; i++) pat_v[i+1] = vp[i];
    model_run(4, 18);
    run_cycles(18);
    for (int i = 0; i < 18; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL gapped_load cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
  endtask

  task automatic test_zero_count();
    logic [47:0] m;
    set_pattern(0, 10, 50);
    model_run(0, 10);
    run_cycles(10);
    for (int i = 0; i < 10; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL zero_count cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
  endtask

  task automatic test_random_loads();
    logic [47:0] m;
    int          n, r, lim, cnt;
    for (int t = 0; t < 8; t++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      n = 0;
      else if (r == 1) n = 1025 + int'($urandom_range(0, 1022));
      else             n = int'($urandom_range(1, 16));
      set_pattern(n, 64, int'($urandom_range(30, 90)));
      // Guarantee the load finishes inside the window so the next Start is accepted.
      lim = 64 - RD - 3;
      cnt = 0;
      for (int i = 1; i <= lim; i++) cnt += int'(pat_v[i]);
      for (int i = lim; i >= 1; i--) begin
        if (cnt < n && !pat_v[i]) begin
          pat_v[i] = 1'b1;
          cnt++;
        end
      end
      model_run(n, 64);
      run_cycles(64);
      for (int i = 0; i < 64; i++) begin
        m = mask_of(exp_vec[i]);
        total++;
        if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
          bad++;
          $display("FAIL random_load n=%0d cyc=%0d got=%h want=%h", n, i, obs_vec[i] & m, exp_vec[i] & m);
        end
      end
    end
  endtask

  task automatic test_full_depth();
    logic [47:0] m;
    set_pattern(1024, 1032, 100);
    model_run(1024, 1032);
    run_cycles(1032);
    for (int i = 0; i < 1032; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL full_depth cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [47:0] m;
    // Two of five words accepted, then reset lands before the next edge.
    set_pattern(5, 4, 100);
    model_run(5, 4);
    run_cycles(4);
    for (int i = 0; i < 4; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL midload_pre cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
    #2 Rst = 1'b1;
    #1;
    total++;
    if (obs_now() !== RST_VEC) begin
      bad++;
      $display("FAIL midload_rst got=%h want=%h", obs_now(), RST_VEC);
    end
    @(negedge Clk);
    Rst = 1'b0;
    cur_running = 1'b0;
    cur_err     = 1'b0;
    // Reload two words; a Start arriving mid-LOAD must have no effect.
    set_pattern(2, 12, 100);
    pat_s[2]  = 1'b1;
    pat_wc[2] = 11'd3;
    model_run(2, 12);
    run_cycles(12);
    for (int i = 0; i < 12; i++) begin
      m = mask_of(exp_vec[i]);
      total++;
      if ((obs_vec[i] & m) !== (exp_vec[i] & m)) begin
        bad++;
        $display("FAIL midload_reload cyc=%0d got=%h want=%h", i, obs_vec[i] & m, exp_vec[i] & m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bad_count();
    test_basic_load();
    test_gapped_load();
    test_zero_count();
    test_random_loads();
    test_full_depth();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
